// File: rtl/uart_io_endpoint.sv
`timescale 1ns/1ps
// uart_io_endpoint
// Peripheral-side endpoint of the IO register interface. It implements an
// 8N1 UART with a small TX FIFO and a single-byte RX holding register.
// The CPU registers are level-held with no strobes, so every CPU command is
// signalled by a change in a sequence field. This block detects those changes.
//
// Parameters:
//   CLK_DIV  - clock cycles per UART bit (4..65535)
//   TX_DEPTH - TX FIFO entries (2, 4 or 8)
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   tx_data    - byte to transmit
//   tx_seq     - a change of value pushes tx_data into the TX FIFO
//   rx_ack_seq - last rx_seq value consumed by the CPU
//   clr_seq    - a change of value clears the sticky error flags
//   io_status  - registered status word:
//                [7:0] rx_data, [15:8] rx_seq, [16] rx_pending, [17] tx_full,
//                [18] tx_busy, [19] rx_overrun, [20] rx_frame_err,
//                [21] tx_drop, [27:24] TX FIFO occupancy, others 0
//   uart_tx    - serial output, idle high
//   uart_rx    - serial input, asynchronous
//   loopback   - only with UART_LOOPBACK_EN: routes TX into RX, holds pin high
//
// Optional feature macro: UART_LOOPBACK_EN
module uart_io_endpoint #(
  parameter int CLK_DIV  = 868,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic [7:0]  tx_seq,
  input  logic [7:0]  rx_ack_seq,
  input  logic [7:0]  clr_seq,
  output logic [31:0] io_status,
  output logic        uart_tx,
  input  logic        uart_rx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic        loopback
`endif
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic             r_primed;
  logic [7:0]       r_lastTxSeq;
  logic [7:0]       r_lastClrSeq;
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  txState_t         r_txState;
  txState_t         w_txNext;
  logic [15:0]      r_txBaud;
  logic [2:0]       r_txBit;
  logic [7:0]       r_txShift;
  logic             r_txOut;

  rxState_t         r_rxState;
  rxState_t         w_rxNext;
  logic [15:0]      r_rxBaud;
  logic [2:0]       r_rxBit;
  logic [7:0]       r_rxShift;
  logic [7:0]       r_rxData;
  logic [7:0]       r_rxSeq;
  logic             r_rxSync1;
  logic             r_rxSync2;

  logic             r_rxOverrun;
  logic             r_rxFrameErr;
  logic             r_txDrop;
  logic [31:0]      r_status;

  logic w_push, w_wr, w_drop, w_clear, w_full, w_empty, w_pop;
  logic w_txBaudDone, w_txBaudClr, w_txBusy;
  logic w_rxBaudClr, w_rxShiftEn, w_rxGood, w_rxBad, w_rxPending;
  logic w_rxIn, w_rxSerialIn;

`ifdef UART_LOOPBACK_EN
  assign w_rxSerialIn = loopback ? r_txOut : uart_rx;
  assign uart_tx      = loopback ? 1'b1 : r_txOut;
`else
  assign w_rxSerialIn = uart_rx;
  assign uart_tx      = r_txOut;
`endif

  assign w_rxIn      = r_rxSync2;
  assign w_full      = (r_count == DEPTH_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = r_primed && (tx_seq != r_lastTxSeq);
  assign w_clear     = r_primed && (clr_seq != r_lastClrSeq);
  assign w_wr        = w_push && !w_full;
  assign w_drop      = w_push && w_full;
  assign w_rxPending = (r_rxSeq != rx_ack_seq);
  assign w_txBusy    = !w_empty || (r_txState != TX_IDLE);
  assign io_status   = r_status;

  // The first edge after reset only captures the sequence fields, so a
  // non-zero value already present at reset release is not seen as a command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed     <= 1'b0;
      r_lastTxSeq  <= 8'd0;
      r_lastClrSeq <= 8'd0;
    end else begin
      r_primed     <= 1'b1;
      r_lastTxSeq  <= tx_seq;
      r_lastClrSeq <= clr_seq;
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wrPtr] <= tx_data;
  end

  // Pointers wrap naturally because TX_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_txState <= TX_IDLE;
    else        r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext     = r_txState;
    w_pop        = 1'b0;
    w_txBaudClr  = 1'b0;
    w_txBaudDone = (r_txBaud == BAUD_LAST);
    case (r_txState)
      TX_IDLE: begin
        w_txBaudClr = 1'b1;
        if (!w_empty) begin
          w_txNext = TX_START;
          w_pop    = 1'b1;
        end
      end
      TX_START: if (w_txBaudDone) begin
        w_txBaudClr = 1'b1;
        w_txNext    = TX_DATA;
      end
      TX_DATA: if (w_txBaudDone) begin
        w_txBaudClr = 1'b1;
        if (r_txBit == 3'd7) w_txNext = TX_STOP;
      end
      TX_STOP: if (w_txBaudDone) begin
        w_txBaudClr = 1'b1;
        // Chain straight into the next frame when more bytes are queued.
        if (!w_empty) begin
          w_txNext = TX_START;
          w_pop    = 1'b1;
        end else begin
          w_txNext = TX_IDLE;
        end
      end
      default: w_txNext = TX_IDLE;
    endcase
  end

  // The serial output is registered: a pop drives the start bit on the same
  // edge, and each bit change happens on the edge that ends the previous bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txBaud  <= 16'd0;
      r_txBit   <= 3'd0;
      r_txShift <= 8'd0;
      r_txOut   <= 1'b1;
    end else begin
      r_txBaud <= w_txBaudClr ? 16'd0 : r_txBaud + 16'd1;
      if (r_txState != TX_DATA)  r_txBit <= 3'd0;
      else if (w_txBaudDone)     r_txBit <= r_txBit + 3'd1;
      if (w_pop) begin
        r_txShift <= r_fifo[r_rdPtr];
        r_txOut   <= 1'b0;
      end else if (w_txBaudDone) begin
        case (r_txState)
          TX_START: r_txOut <= r_txShift[0];
          TX_DATA: begin
            r_txShift <= {1'b0, r_txShift[7:1]};
            r_txOut   <= (r_txBit == 3'd7) ? 1'b1 : r_txShift[1];
          end
          TX_STOP: r_txOut <= 1'b1;
          default: r_txOut <= r_txOut;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxState <= RX_IDLE;
    end else begin
      r_rxSync1 <= w_rxSerialIn;
      r_rxSync2 <= r_rxSync1;
      r_rxState <= w_rxNext;
    end
  end

  // The start bit is re-checked half a bit after the falling edge so that
  // short glitches are rejected; later samples then fall near bit centres.
  always_comb begin
    w_rxNext    = r_rxState;
    w_rxBaudClr = 1'b0;
    w_rxShiftEn = 1'b0;
    w_rxGood    = 1'b0;
    w_rxBad     = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        w_rxBaudClr = 1'b1;
        if (!w_rxIn) w_rxNext = RX_START;
      end
      RX_START: if (r_rxBaud == HALF_LAST) begin
        w_rxBaudClr = 1'b1;
        w_rxNext    = w_rxIn ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rxBaud == BAUD_LAST) begin
        w_rxBaudClr = 1'b1;
        w_rxShiftEn = 1'b1;
        if (r_rxBit == 3'd7) w_rxNext = RX_STOP;
      end
      RX_STOP: if (r_rxBaud == BAUD_LAST) begin
        w_rxBaudClr = 1'b1;
        w_rxNext    = RX_IDLE;
        w_rxGood    = w_rxIn;
        w_rxBad     = !w_rxIn;
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  // Sticky flags: a set event on the same edge as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxBaud     <= 16'd0;
      r_rxBit      <= 3'd0;
      r_rxShift    <= 8'd0;
      r_rxData     <= 8'd0;
      r_rxSeq      <= 8'd0;
      r_rxOverrun  <= 1'b0;
      r_rxFrameErr <= 1'b0;
      r_txDrop     <= 1'b0;
      r_status     <= 32'd0;
    end else begin
      r_rxBaud <= w_rxBaudClr ? 16'd0 : r_rxBaud + 16'd1;
      if (r_rxState != RX_DATA) r_rxBit <= 3'd0;
      else if (w_rxShiftEn)     r_rxBit <= r_rxBit + 3'd1;
      if (w_rxShiftEn) r_rxShift <= {w_rxIn, r_rxShift[7:1]};
      if (w_rxGood) begin
        r_rxData <= r_rxShift;
        r_rxSeq  <= r_rxSeq + 8'd1;
      end
      if (w_rxGood && w_rxPending) r_rxOverrun  <= 1'b1;
      else if (w_clear)            r_rxOverrun  <= 1'b0;
      if (w_rxBad)                 r_rxFrameErr <= 1'b1;
      else if (w_clear)            r_rxFrameErr <= 1'b0;
      if (w_drop)                  r_txDrop     <= 1'b1;
      else if (w_clear)            r_txDrop     <= 1'b0;
      r_status <= {4'd0, 4'(r_count), 2'd0, r_txDrop, r_rxFrameErr,
                   r_rxOverrun, w_txBusy, w_full, w_rxPending,
                   r_rxSeq, r_rxData};
    end
  end

endmodule

// File: tb/tb_uart_io_endpoint.sv
`timescale 1ns/1ps
// tb_uart_io_endpoint
// Self-checking bench for uart_io_endpoint with CLK_DIV=4, TX_DEPTH=4.
// A serial monitor decodes every frame on uart_tx and compares it against a
// queue of accepted bytes; RX frames are driven bit by bit and the expected
// register state is derived from the receive rules.
module tb_uart_io_endpoint;

  localparam int CLK_DIV  = 4;
  localparam int TX_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic [7:0]  tx_seq;
  logic [7:0]  rx_ack_seq;
  logic [7:0]  clr_seq;
  logic [31:0] io_status;
  logic        uart_tx;
  logic        uart_rx;
`ifdef UART_LOOPBACK_EN
  logic        loopback;
`endif

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] modelFifo[$];
  int         txInFlight = 0;
  int         resetGen   = 0;
  logic [7:0] rxDataM    = 8'd0;
  logic [7:0] rxSeqM     = 8'd0;
  logic       ovM        = 1'b0;
  logic       feM        = 1'b0;
  logic       dropM      = 1'b0;

  uart_io_endpoint #(.CLK_DIV(CLK_DIV), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_seq(tx_seq),
    .rx_ack_seq(rx_ack_seq),
    .clr_seq(clr_seq),
    .io_status(io_status),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback(loopback)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expected);
    checkCount++;
    if (got !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  // Compares every status field against the bench's register model.
  task automatic checkStatus(input string tag, input int expOcc, input logic expBusy);
    checkOutput({tag, ".rxData"},  io_status[7:0], rxDataM);
    checkOutput({tag, ".rxSeq"},   io_status[15:8], rxSeqM);
    checkOutput({tag, ".pending"}, io_status[16], rxSeqM != rx_ack_seq);
    checkOutput({tag, ".txFull"},  io_status[17], expOcc == TX_DEPTH);
    checkOutput({tag, ".txBusy"},  io_status[18], expBusy);
    checkOutput({tag, ".overrun"}, io_status[19], ovM);
    checkOutput({tag, ".frameErr"}, io_status[20], feM);
    checkOutput({tag, ".txDrop"},  io_status[21], dropM);
    checkOutput({tag, ".occ"},     io_status[27:24], expOcc);
    checkOutput({tag, ".zeroBits"}, {io_status[31:28], io_status[23:22]}, 0);
  endtask

  // Pushes one byte by changing tx_seq (delta 0 picks a random jump).
  task automatic applyStimulus(input logic [7:0] data, input int delta, input bit modelled);
    tx_data = data;
    if (delta == 0) tx_seq = tx_seq + 8'($urandom_range(1, 255));
    else            tx_seq = tx_seq + 8'(delta);
    if (modelled) begin
      if (modelFifo.size() - txInFlight < TX_DEPTH) modelFifo.push_back(data);
      else dropM = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic sendRxFrame(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rx = frame[b];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    if (stopBit) begin
      if (rxSeqM != rx_ack_seq) ovM = 1'b1;
      rxDataM = data;
      rxSeqM  = rxSeqM + 8'd1;
    end else begin
      feM = 1'b1;
    end
  endtask

  task automatic clearFlags();
    clr_seq = clr_seq + 8'($urandom_range(1, 255));
    ovM = 1'b0; feM = 1'b0; dropM = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitTxDrain(input int maxCycles);
    for (int i = 0; i < maxCycles && (modelFifo.size() != 0 || txInFlight != 0); i++)
      @(negedge clk);
    checkOutput("txDrain", modelFifo.size() + txInFlight, 0);
    repeat (5) @(negedge clk);
  endtask

  // Serial monitor: decodes frames at bit centres and checks them in order.
  logic [7:0] monByte;
  logic       monStop;
  int         monGen;
  logic [8:0] monExp;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        monGen     = resetGen;
        txInFlight = 1;
        repeat (CLK_DIV + 1) @(negedge clk);
        monByte[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          monByte[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        monStop = uart_tx;
        if (monGen == resetGen) begin
          monExp = (modelFifo.size() > 0) ? {1'b0, modelFifo.pop_front()} : 9'h100;
          checkOutput("txFrameByte", {1'b0, monByte}, monExp);
          checkOutput("txStopBit", monStop, 1'b1);
        end
        txInFlight = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] wave;
    logic [7:0] b;
    int lows;
    rst_n = 1'b0; tx_seq = 8'h05; tx_data = 8'h00; clr_seq = 8'h00;
    rx_ack_seq = 8'h00; uart_rx = 1'b1;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] reset release and priming");
    checkOutput("resetStatus", io_status, 32'd0);
    checkOutput("resetTx", uart_tx, 1'b1);
    checkStatus("primed", 0, 1'b0);

    $display("[TB] single frame waveform");
    wave = {1'b1, 8'hA5, 1'b0};
    applyStimulus(8'hA5, 1, 1'b1);
    checkOutput("txPreStart", uart_tx, 1'b1);
    for (int k = 2; k <= 41; k++) begin
      @(negedge clk);
      checkOutput("txWave", uart_tx, wave[(k - 2) / CLK_DIV]);
      checkOutput("txBusyMid", io_status[18], 1'b1);
    end
    waitTxDrain(100);
    checkStatus("afterFirst", 0, 1'b0);

    $display("[TB] FIFO fill and drop");
    applyStimulus(8'($urandom), 0, 1'b1);
    repeat (9) @(negedge clk);
    for (int p = 0; p < 5; p++) applyStimulus(8'($urandom), 0, 1'b1);
    repeat (2) @(negedge clk);
    checkStatus("fifoFull", modelFifo.size() - txInFlight, 1'b1);
    waitTxDrain(400);
    checkStatus("drained", 0, 1'b0);
    clearFlags();
    checkStatus("dropCleared", 0, 1'b0);

    $display("[TB] receive path");
    sendRxFrame(8'h3C, 1'b1);
    checkStatus("rx3C", 0, 1'b0);
    rx_ack_seq = rxSeqM;
    repeat (3) @(negedge clk);
    checkStatus("rxAck", 0, 1'b0);
    sendRxFrame(8'h11, 1'b1);
    sendRxFrame(8'h22, 1'b1);
    checkStatus("rxOverrun", 0, 1'b0);
    sendRxFrame(8'($urandom), 1'b0);
    checkStatus("rxFrameErr", 0, 1'b0);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    checkStatus("rxFalseStart", 0, 1'b0);
    clearFlags();
    checkStatus("rxCleared", 0, 1'b0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < $urandom_range(1, 3); p++) applyStimulus(8'($urandom), 0, 1'b1);
      b = 8'($urandom);
      sendRxFrame(b, ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) rx_ack_seq = rxSeqM;
      if ($urandom_range(0, 2) == 0) clearFlags();
      waitTxDrain(400);
      checkStatus("random", 0, 1'b0);
    end

`ifdef UART_LOOPBACK_EN
    $display("[TB] loopback");
    loopback = 1'b1;
    applyStimulus(8'h5A, 0, 1'b0);
    lows = 0;
    for (int c = 0; c < 70; c++) begin
      if (uart_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    checkOutput("loopPinHigh", lows, 0);
    if (rxSeqM != rx_ack_seq) ovM = 1'b1;
    rxDataM = 8'h5A;
    rxSeqM  = rxSeqM + 8'd1;
    loopback = 1'b0;
    repeat (3) @(negedge clk);
    checkStatus("loopback", 0, 1'b0);
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, 0, 1'b1);
    repeat (11) @(negedge clk);
    checkOutput("preResetTx", uart_tx, 1'b0);
    #2;
    rst_n = 1'b0;
    resetGen++;
    modelFifo.delete();
    txInFlight = 0;
    #1;
    checkOutput("asyncResetTx", uart_tx, 1'b1);
    checkOutput("asyncResetStatus", io_status, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rxDataM = 8'd0; rxSeqM = 8'd0; ovM = 1'b0; feM = 1'b0; dropM = 1'b0;
    repeat (5) @(negedge clk);
    checkStatus("afterReset", 0, 1'b0);
    checkOutput("afterResetTx", uart_tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
